// File: rtl/lpcas_sar_ctrl.sv
// lpcas_sar_ctrl: successive-approximation controller for the LPCAS analog tile.
// It sequences sample -> binary-search trials -> done. DAC code and sample switch
// are driven from registers, so there is no combinational path from comp_in or start.
module lpcas_sar_ctrl #(
   parameter int unsigned NBITS         = 8,
   parameter int unsigned SAMPLE_CYCLES = 2,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             comp_in,
   output logic             sample_en,
   output logic [NBITS-1:0] dac_code,
   output logic             busy,
   output logic [NBITS-1:0] result,
   output logic             valid
);

   localparam int unsigned MAXC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int unsigned BW   = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [CW-1:0]    SMP_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0]    STL_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [BW-1:0]    TOP_BIT  = BW'(NBITS - 1);
   localparam logic [NBITS-1:0] ONE      = NBITS'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAMPLE,
      S_TRIAL,
      S_DONE
   } state_t;

   state_t           r_state, w_state;
   logic [CW-1:0]    r_cnt, w_cnt;
   logic [BW-1:0]    r_bit, w_bit;
   logic [NBITS-1:0] r_code, w_code;
   logic [NBITS-1:0] r_result, w_result;
   logic [NBITS-1:0] r_dac, w_dac;
   logic             r_sample_en, w_sample_en;
   logic             r_busy, w_busy;
   logic             r_valid, w_valid;
   logic [NBITS-1:0] w_trial;
   logic [NBITS-1:0] w_kept;

   // State and registered-output update; async reset to idle values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= TOP_BIT;
         r_code      <= '0;
         r_result    <= '0;
         r_dac       <= '0;
         r_sample_en <= 1'b0;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_bit       <= w_bit;
         r_code      <= w_code;
         r_result    <= w_result;
         r_dac       <= w_dac;
         r_sample_en <= w_sample_en;
         r_busy      <= w_busy;
         r_valid     <= w_valid;
      end
   end

   // Next-state logic; output values are computed for the cycle after the edge.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_bit       = r_bit;
      w_code      = r_code;
      w_result    = r_result;
      w_dac       = '0;
      w_sample_en = 1'b0;
      w_busy      = 1'b1;
      w_valid     = 1'b0;
      w_trial     = r_code | (ONE << r_bit);
      w_kept      = comp_in ? w_trial : r_code;

      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               w_state     = S_SAMPLE;
               w_cnt       = '0;
               w_code      = '0;
               w_sample_en = 1'b1;
               w_busy      = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (r_cnt == SMP_LAST) begin
               w_state = S_TRIAL;
               w_cnt   = '0;
               w_bit   = TOP_BIT;
               w_dac   = r_code | (ONE << TOP_BIT);
            end else begin
               w_cnt       = r_cnt + CW'(1);
               w_sample_en = 1'b1;
            end
         end
         S_TRIAL: begin
            if (r_cnt == STL_LAST) begin
               w_code = w_kept;
               w_cnt  = '0;
               if (r_bit == '0) begin
                  w_state  = S_DONE;
                  w_result = w_kept;
                  w_valid  = 1'b1;
               end else begin
                  // next trial code already carries this bit's decision
                  w_bit = r_bit - BW'(1);
                  w_dac = w_kept | (ONE << (r_bit - BW'(1)));
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
               w_dac = w_trial;
            end
         end
         S_DONE: begin
            if (cont || start) begin
               w_state     = S_SAMPLE;
               w_cnt       = '0;
               w_code      = '0;
               w_sample_en = 1'b1;
            end else begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   assign sample_en = r_sample_en;
   assign dac_code  = r_dac;
   assign busy      = r_busy;
   assign result    = r_result;
   assign valid     = r_valid;

endmodule

// File: tb/tb_lpcas_sar_ctrl.sv
// Directed bench for lpcas_sar_ctrl: default instance (8/2/1) and a 8/3/2 instance.
module tb_lpcas_sar_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start6, cont;
   logic [7:0] vin;
   int         comp_mode;   // 0: comparator model, 1: tied 1, 2: tied 0
   logic       comp0, comp6;

   logic       se0, busy0, val0, se6, busy6, val6;
   logic [7:0] dac0, res0, dac6, res6;

   int ntotal = 0;
   int npass  = 0;

   // run() knobs and logs
   bit         use6;
   bit         spur;
   int         vchg_c, cdrop_c;
   logic [7:0] vin_next;
   int         vfirst, vlast, vcount, bidle, secount;
   logic [7:0] rfirst, rlast;
   logic [7:0] daclog [0:63];
   logic [7:0] exp_seq [0:7];

   logic       o_se, o_busy, o_val;
   logic [7:0] o_dac, o_res;

   always #5 clk = ~clk;

   assign comp0 = (comp_mode == 0) ? (dac0 <= vin) : (comp_mode == 1);
   assign comp6 = (dac6 <= vin);

   assign o_se   = use6 ? se6   : se0;
   assign o_busy = use6 ? busy6 : busy0;
   assign o_val  = use6 ? val6  : val0;
   assign o_dac  = use6 ? dac6  : dac0;
   assign o_res  = use6 ? res6  : res0;

   lpcas_sar_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont), .comp_in(comp0),
      .sample_en(se0), .dac_code(dac0), .busy(busy0), .result(res0), .valid(val0)
   );

   lpcas_sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(3), .SETTLE_CYCLES(2)) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start6), .cont(1'b0), .comp_in(comp6),
      .sample_en(se6), .dac_code(dac6), .busy(busy6), .result(res6), .valid(val6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse start on the selected instance; log ncyc cycles after the start edge.
   task automatic run(input int ncyc);
      vfirst = 0; vlast = 0; vcount = 0; bidle = 0; secount = 0;
      rfirst = '0; rlast = '0;
      for (int i = 0; i < 64; i++) daclog[i] = '0;
      if (use6) start6 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start6 = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (o_val) begin
            vcount++;
            if (vfirst == 0) begin vfirst = c; rfirst = o_res; end
            vlast = c;
            rlast = o_res;
         end
         if (!o_busy && bidle == 0) bidle = c;
         if (o_se) secount++;
         daclog[c] = o_dac;
         start0 = spur && (c == 5 || c == 7);
         if (c == vchg_c) vin = vin_next;
         if (c == cdrop_c) cont = 1'b0;
         tick();
      end
      start0 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start6 = 1'b0; cont = 1'b0;
      vin = 8'h00; comp_mode = 0; use6 = 1'b0; spur = 1'b0;
      vchg_c = 0; cdrop_c = 0; vin_next = 8'h00;
      #12;
      chk("rst_sample_en", {31'd0, se0}, 32'd0);
      chk("rst_dac", {24'd0, dac0}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_result", {24'd0, res0}, 32'd0);
      chk("rst_valid", {31'd0, val0}, 32'd0);
      chk("rst6_busy", {31'd0, busy6}, 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // 1: Vin = 0xA5 single conversion
      vin = 8'hA5;
      exp_seq[0] = 8'h80; exp_seq[1] = 8'hC0; exp_seq[2] = 8'hA0; exp_seq[3] = 8'hB0;
      exp_seq[4] = 8'hA8; exp_seq[5] = 8'hA4; exp_seq[6] = 8'hA6; exp_seq[7] = 8'hA5;
      run(15);
      chk("t1_valid_cycle", vfirst, 11);
      chk("t1_valid_count", vcount, 1);
      chk("t1_result", {24'd0, rfirst}, 32'hA5);
      chk("t1_sample_cycles", secount, 2);
      chk("t1_idle_cycle", bidle, 12);
      for (int i = 0; i < 8; i++) chk("t1_trial_code", {24'd0, daclog[3+i]}, {24'd0, exp_seq[i]});
      chk("t1_done_dac", {24'd0, daclog[11]}, 32'd0);

      // 2: comparator tied 1 / tied 0
      comp_mode = 1;
      run(14);
      chk("t2_tied1_result", {24'd0, rfirst}, 32'hFF);
      comp_mode = 2;
      run(14);
      chk("t2_tied0_result", {24'd0, rfirst}, 32'h00);
      chk("t2_tied0_valid", vcount, 1);
      for (int i = 0; i < 8; i++) chk("t2_tied0_code", {24'd0, daclog[3+i]}, 32'h80 >> i);
      comp_mode = 0;

      // 3: continuous mode, Vin steps between conversions, cont dropped mid second run
      vin = 8'h10; vin_next = 8'h3C; vchg_c = 11; cdrop_c = 12; cont = 1'b1;
      run(25);
      chk("t3_valid_count", vcount, 2);
      chk("t3_first_cycle", vfirst, 11);
      chk("t3_second_cycle", vlast, 22);
      chk("t3_first_result", {24'd0, rfirst}, 32'h10);
      chk("t3_second_result", {24'd0, rlast}, 32'h3C);
      chk("t3_busy_first_drop", bidle, 23);
      vchg_c = 0; cdrop_c = 0;

      // 4: spurious start pulses during TRIAL
      vin = 8'h37; spur = 1'b1;
      run(15);
      chk("t4_valid_count", vcount, 1);
      chk("t4_valid_cycle", vfirst, 11);
      chk("t4_result", {24'd0, rfirst}, 32'h37);
      chk("t4_idle_cycle", bidle, 12);
      spur = 1'b0;

      // 5: reset during TRIAL(bit 4); vin 0x3C -> code 0x20, trial 0x30
      vin = 8'h3C;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (5) tick();
      chk("t5_trial_bit4", {24'd0, dac0}, 32'h30);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_dac", {24'd0, dac0}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy0}, 32'd0);
      chk("t5_rst_result", {24'd0, res0}, 32'd0);
      chk("t5_rst_valid", {31'd0, val0}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      vin = 8'h5A;
      run(14);
      chk("t5_fresh_result", {24'd0, rfirst}, 32'h5A);
      chk("t5_fresh_cycle", vfirst, 11);
      chk("t5_fresh_first_trial", {24'd0, daclog[3]}, 32'h80);

      // 6: SAMPLE_CYCLES=3, SETTLE_CYCLES=2 instance, Vin = 0xA5
      use6 = 1'b1; vin = 8'hA5;
      run(25);
      chk("t6_sample_cycles", secount, 3);
      chk("t6_valid_cycle", vfirst, 20);
      chk("t6_valid_count", vcount, 1);
      chk("t6_result", {24'd0, rfirst}, 32'hA5);
      chk("t6_code_c4", {24'd0, daclog[4]}, 32'h80);
      chk("t6_code_c5", {24'd0, daclog[5]}, 32'h80);
      chk("t6_code_c6", {24'd0, daclog[6]}, 32'hC0);
      chk("t6_code_c7", {24'd0, daclog[7]}, 32'hC0);
      chk("t6_code_c19", {24'd0, daclog[19]}, 32'hA5);
      chk("t6_idle_cycle", bidle, 21);
      use6 = 1'b0;

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
